// File: rtl/collision_flag_updater_if.sv
// Bus between the collision controller and the flag updater.
// The controller (master) drives pair requests; the updater (slave) returns the published flags.
interface collision_flag_updater_if #(
   parameter int N_SPRITE  = 32,
   parameter int SEL_BITS  = 5,
   parameter int DATA_BITS = 32
);
   logic                 enable_refresh_flags;
   logic                 reset_refresh_mod;
   logic                 analyze_process_finished;
   logic [SEL_BITS-1:0]  number_of_mobile_sprite;
   logic [SEL_BITS-1:0]  number_of_comparison_sprite;
   logic [DATA_BITS-1:0] out_m_sprite;
   logic [DATA_BITS-1:0] out_c_sprite;
   logic [N_SPRITE-1:0]  collision_flags;
   logic                 flags_valid;
   logic [7:0]           collision_count;

   modport master (
      output enable_refresh_flags, reset_refresh_mod, analyze_process_finished,
      output number_of_mobile_sprite, number_of_comparison_sprite,
      output out_m_sprite, out_c_sprite,
      input  collision_flags, flags_valid, collision_count
   );

   modport slave (
      input  enable_refresh_flags, reset_refresh_mod, analyze_process_finished,
      input  number_of_mobile_sprite, number_of_comparison_sprite,
      input  out_m_sprite, out_c_sprite,
      output collision_flags, flags_valid, collision_count
   );
endinterface

// File: rtl/collision_flag_updater.sv
// Three-stage sprite pair overlap pipeline that accumulates sticky per-sprite collision
// flags and publishes a snapshot once the collision pass has finished and the pipeline drained.
module collision_flag_updater #(
   parameter int N_SPRITE    = 32,
   parameter int SEL_BITS    = 5,
   parameter int DATA_BITS   = 32,
   parameter int SPRITE_SIZE = 20
) (
   input logic clk,
   input logic reset,
   collision_flag_updater_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;

   // Magnitude of the difference of two 10-bit coordinates.
   function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      logic signed [10:0] d_s;
      d_s = $signed({1'b0, a}) - $signed({1'b0, b});
      abs_diff = d_s[10] ? $unsigned(-d_s) : $unsigned(d_s);
   endfunction

   state_t               state_r, state_next_s;
   logic                 en_prev_r, fin_prev_r;
   logic                 req_edge_s, fin_fall_s;
   logic                 s1_valid_r, s1_act_m_r, s1_act_c_r;
   logic [SEL_BITS-1:0]  s1_idx_m_r, s1_idx_c_r;
   logic [9:0]           s1_xm_r, s1_ym_r, s1_xc_r, s1_yc_r;
   logic                 hit_s;
   logic                 s2_valid_r, s2_hit_r;
   logic [SEL_BITS-1:0]  s2_idx_m_r, s2_idx_c_r;
   logic [N_SPRITE-1:0]  set_mask_s, working_r, working_next_s;
   logic [7:0]           pair_cnt_r, pair_cnt_next_s;
   logic [N_SPRITE-1:0]  collision_flags_r;
   logic [7:0]           collision_count_r;
   logic                 flags_valid_r;

   assign req_edge_s = bus.enable_refresh_flags & ~en_prev_r;
   assign fin_fall_s = ~bus.analyze_process_finished & fin_prev_r;

   // Edge-detect history and the S1 capture stage.
   always_ff @(posedge clk) begin
      if (!reset) begin
         en_prev_r  <= 1'b0;
         fin_prev_r <= 1'b0;
         s1_valid_r <= 1'b0;
         s1_act_m_r <= 1'b0;
         s1_act_c_r <= 1'b0;
         s1_idx_m_r <= '0;
         s1_idx_c_r <= '0;
         s1_xm_r    <= 10'd0;
         s1_ym_r    <= 10'd0;
         s1_xc_r    <= 10'd0;
         s1_yc_r    <= 10'd0;
      end else begin
         en_prev_r  <= bus.enable_refresh_flags;
         fin_prev_r <= bus.analyze_process_finished;
         s1_valid_r <= req_edge_s & bus.reset_refresh_mod;
         if (req_edge_s) begin
            s1_act_m_r <= bus.out_m_sprite[29];
            s1_act_c_r <= bus.out_c_sprite[29];
            s1_idx_m_r <= bus.number_of_mobile_sprite;
            s1_idx_c_r <= bus.number_of_comparison_sprite;
            s1_xm_r    <= bus.out_m_sprite[28:19];
            s1_ym_r    <= bus.out_m_sprite[18:9];
            s1_xc_r    <= bus.out_c_sprite[28:19];
            s1_yc_r    <= bus.out_c_sprite[18:9];
         end else begin
            s1_act_m_r <= s1_act_m_r;
            s1_act_c_r <= s1_act_c_r;
            s1_idx_m_r <= s1_idx_m_r;
            s1_idx_c_r <= s1_idx_c_r;
            s1_xm_r    <= s1_xm_r;
            s1_ym_r    <= s1_ym_r;
            s1_xc_r    <= s1_xc_r;
            s1_yc_r    <= s1_yc_r;
         end
      end
   end

   // Out-of-range indices never count as a hit, so they neither set flags nor count.
   assign hit_s = s1_act_m_r & s1_act_c_r & (s1_idx_m_r != s1_idx_c_r)
                & (32'(s1_idx_m_r) < 32'(N_SPRITE)) & (32'(s1_idx_c_r) < 32'(N_SPRITE))
                & (abs_diff(s1_xm_r, s1_xc_r) < 11'(SPRITE_SIZE))
                & (abs_diff(s1_ym_r, s1_yc_r) < 11'(SPRITE_SIZE));

   // S2 stage: registered hit decision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s2_valid_r <= 1'b0;
         s2_hit_r   <= 1'b0;
         s2_idx_m_r <= '0;
         s2_idx_c_r <= '0;
      end else begin
         s2_valid_r <= s1_valid_r & bus.reset_refresh_mod;
         s2_hit_r   <= hit_s;
         s2_idx_m_r <= s1_idx_m_r;
         s2_idx_c_r <= s1_idx_c_r;
      end
   end

   // S3 update: sticky flag set and saturating pair count; clear wins.
   always_comb begin
      set_mask_s      = '0;
      working_next_s  = working_r;
      pair_cnt_next_s = pair_cnt_r;
      for (int i = 0; i < N_SPRITE; i++) begin
         if ((s2_idx_m_r == SEL_BITS'(i)) || (s2_idx_c_r == SEL_BITS'(i))) begin
            set_mask_s[i] = 1'b1;
         end else begin
            set_mask_s[i] = 1'b0;
         end
      end
      if (!bus.reset_refresh_mod) begin
         working_next_s  = '0;
         pair_cnt_next_s = 8'd0;
      end else if (s2_valid_r && s2_hit_r) begin
         working_next_s  = working_r | set_mask_s;
         pair_cnt_next_s = (pair_cnt_r == 8'd255) ? 8'd255 : pair_cnt_r + 8'd1;
      end else begin
         working_next_s  = working_r;
         pair_cnt_next_s = pair_cnt_r;
      end
   end

   // Publish FSM next state.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (fin_fall_s) state_next_s = ST_DRAIN;
            else            state_next_s = ST_IDLE;
         end
         ST_DRAIN: begin
            if (!bus.reset_refresh_mod)                          state_next_s = ST_IDLE;
            else if (!s1_valid_r && !s2_valid_r && !req_edge_s) state_next_s = ST_PUBLISH;
            else                                                  state_next_s = ST_DRAIN;
         end
         ST_PUBLISH: state_next_s = ST_IDLE;
         default:    state_next_s = ST_IDLE;
      endcase
   end

   // Working state, FSM register and published snapshot.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r           <= ST_IDLE;
         working_r         <= '0;
         pair_cnt_r        <= 8'd0;
         collision_flags_r <= '0;
         collision_count_r <= 8'd0;
         flags_valid_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         working_r  <= working_next_s;
         pair_cnt_r <= pair_cnt_next_s;
         if (state_r == ST_PUBLISH) begin
            collision_flags_r <= working_next_s;
            collision_count_r <= pair_cnt_next_s;
            flags_valid_r     <= 1'b1;
         end else begin
            collision_flags_r <= collision_flags_r;
            collision_count_r <= collision_count_r;
            flags_valid_r     <= 1'b0;
         end
      end
   end

   assign bus.collision_flags = collision_flags_r;
   assign bus.collision_count = collision_count_r;
   assign bus.flags_valid     = flags_valid_r;
endmodule

// File: tb/tb_collision_flag_updater.sv
// Directed self-checking bench for collision_flag_updater.
module tb_collision_flag_updater;
   logic clk;
   logic reset;
   int   check_cnt;
   int   error_cnt;
   logic [31:0] exp_snap;

   collision_flag_updater_if #(.N_SPRITE(32), .SEL_BITS(5), .DATA_BITS(32)) bus_if ();

   collision_flag_updater #(
      .N_SPRITE(32), .SEL_BITS(5), .DATA_BITS(32), .SPRITE_SIZE(20)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         error_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] spr(input logic act, input int x, input int y);
      logic [9:0] xv;
      logic [9:0] yv;
      xv = 10'(x);
      yv = 10'(y);
      return {2'b00, act, xv, yv, 9'h000};
   endfunction

   task automatic set_pair(input int m, input int c, input logic [31:0] mw, input logic [31:0] cw);
      bus_if.number_of_mobile_sprite     = 5'(m);
      bus_if.number_of_comparison_sprite = 5'(c);
      bus_if.out_m_sprite                = mw;
      bus_if.out_c_sprite                = cw;
   endtask

   task automatic do_pair(input int m, input int c, input logic [31:0] mw, input logic [31:0] cw);
      set_pair(m, c, mw, cw);
      bus_if.enable_refresh_flags = 1'b1;
      tick();
      bus_if.enable_refresh_flags = 1'b0;
      tick();
   endtask

   task automatic clear_work();
      bus_if.reset_refresh_mod = 1'b0;
      tick();
      bus_if.reset_refresh_mod = 1'b1;
   endtask

   task automatic wait_publish(input string tag, input logic [31:0] exp_flags, input logic [7:0] exp_cnt);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus_if.flags_valid) seen = 1'b1;
         else tick();
      end
      check_val({tag, "_valid_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check_val({tag, "_flags"}, bus_if.collision_flags, exp_flags);
         check_val({tag, "_count"}, 32'(bus_if.collision_count), 32'(exp_cnt));
         tick();
         check_val({tag, "_valid_pulse"}, 32'(bus_if.flags_valid), 32'd0);
         exp_snap = exp_flags;
      end
   endtask

   task automatic finish_pass(input string tag, input logic [31:0] exp_flags, input logic [7:0] exp_cnt);
      bus_if.analyze_process_finished = 1'b0;
      tick();
      bus_if.analyze_process_finished = 1'b1;
      wait_publish(tag, exp_flags, exp_cnt);
   endtask

   task automatic watch_no_publish(input string tag);
      int pulses;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus_if.flags_valid) pulses++;
      end
      check_val({tag, "_no_pulse"}, 32'(pulses), 32'd0);
      check_val({tag, "_held"}, bus_if.collision_flags, exp_snap);
   endtask

   initial begin
      check_cnt = 0;
      error_cnt = 0;
      exp_snap  = 32'h0000_0000;
      reset = 1'b0;
      bus_if.enable_refresh_flags     = 1'b0;
      bus_if.reset_refresh_mod        = 1'b1;
      bus_if.analyze_process_finished = 1'b1;
      set_pair(0, 0, 32'h0000_0000, 32'h0000_0000);
      repeat (3) tick();
      check_val("rst_flags", bus_if.collision_flags, 32'h0000_0000);
      check_val("rst_count", 32'(bus_if.collision_count), 32'd0);
      check_val("rst_valid", 32'(bus_if.flags_valid), 32'd0);
      reset = 1'b1;
      tick();

      // Basic overlapping pair.
      do_pair(0, 3, spr(1'b1, 100, 100), spr(1'b1, 115, 110));
      finish_pass("basic", 32'h0000_0009, 8'd1);

      // Edge of the sprite size: dx = 20 misses, dx = 19 hits.
      clear_work();
      do_pair(0, 3, spr(1'b1, 100, 100), spr(1'b1, 120, 100));
      finish_pass("dx20", 32'h0000_0000, 8'd0);
      clear_work();
      do_pair(0, 3, spr(1'b1, 100, 100), spr(1'b1, 119, 100));
      finish_pass("dx19", 32'h0000_0009, 8'd1);

      // Inactive comparison sprite, and a sprite compared with itself; dy = 19 with x swapped.
      clear_work();
      do_pair(0, 3, spr(1'b1, 100, 100), spr(1'b0, 100, 100));
      do_pair(5, 5, spr(1'b1, 50, 50), spr(1'b1, 50, 50));
      finish_pass("inactive_self", 32'h0000_0000, 8'd0);
      clear_work();
      do_pair(6, 1, spr(1'b1, 200, 119), spr(1'b1, 190, 100));
      finish_pass("dy19_neg", 32'h0000_0042, 8'd1);

      // Several pairs accumulate; published snapshot stays put until the next publish.
      clear_work();
      do_pair(1, 2, spr(1'b1, 10, 10), spr(1'b1, 20, 20));
      do_pair(4, 9, spr(1'b1, 10, 10), spr(1'b1, 300, 300));
      do_pair(10, 31, spr(1'b1, 500, 400), spr(1'b1, 510, 390));
      do_pair(1, 2, spr(1'b1, 10, 10), spr(1'b1, 20, 20));
      check_val("stable_before_publish", bus_if.collision_flags, exp_snap);
      finish_pass("multi", 32'h8000_0406, 8'd3);

      // Last request edge and finish fall in the same cycle.
      clear_work();
      set_pair(2, 7, spr(1'b1, 300, 300), spr(1'b1, 305, 295));
      bus_if.enable_refresh_flags     = 1'b1;
      bus_if.analyze_process_finished = 1'b0;
      tick();
      bus_if.enable_refresh_flags     = 1'b0;
      bus_if.analyze_process_finished = 1'b1;
      wait_publish("same_cycle", 32'h0000_0084, 8'd1);

      // Hit pass, then clear, then a pass with no hits.
      clear_work();
      do_pair(0, 3, spr(1'b1, 100, 100), spr(1'b1, 115, 110));
      clear_work();
      do_pair(0, 3, spr(1'b1, 100, 100), spr(1'b1, 400, 100));
      finish_pass("cleared", 32'h0000_0000, 8'd0);

      // Request held high for five cycles counts once.
      clear_work();
      set_pair(0, 3, spr(1'b1, 100, 100), spr(1'b1, 115, 110));
      bus_if.enable_refresh_flags = 1'b1;
      repeat (5) tick();
      bus_if.enable_refresh_flags = 1'b0;
      tick();
      finish_pass("held", 32'h0000_0009, 8'd1);

      // Pair counter saturates.
      clear_work();
      for (int k = 0; k < 300; k++) begin
         do_pair(0, 3, spr(1'b1, 100, 100), spr(1'b1, 115, 110));
      end
      finish_pass("saturate", 32'h0000_0009, 8'd255);

      // Clear during DRAIN aborts the publish.
      clear_work();
      set_pair(4, 8, spr(1'b1, 60, 60), spr(1'b1, 61, 61));
      bus_if.enable_refresh_flags     = 1'b1;
      bus_if.analyze_process_finished = 1'b0;
      tick();
      bus_if.enable_refresh_flags     = 1'b0;
      bus_if.analyze_process_finished = 1'b1;
      bus_if.reset_refresh_mod        = 1'b0;
      tick();
      bus_if.reset_refresh_mod        = 1'b1;
      watch_no_publish("abort");

      // Reset mid-pipeline and mid-DRAIN.
      set_pair(4, 8, spr(1'b1, 60, 60), spr(1'b1, 61, 61));
      bus_if.enable_refresh_flags     = 1'b1;
      bus_if.analyze_process_finished = 1'b0;
      tick();
      bus_if.enable_refresh_flags     = 1'b0;
      bus_if.analyze_process_finished = 1'b1;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_val("midrst_flags", bus_if.collision_flags, 32'h0000_0000);
      check_val("midrst_count", 32'(bus_if.collision_count), 32'd0);
      exp_snap = 32'h0000_0000;
      watch_no_publish("midrst");

      // After reset the working flags are empty.
      finish_pass("post_rst", 32'h0000_0000, 8'd0);

      $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
      $finish;
   end
endmodule

// File: doc/collision_flag_updater.md
COLLISION_FLAG_UPDATER -- requirements
Module: collision_flag_updater

Interface
REQ-001 Parameter N_SPRITE, default 32: number of sprite slots and width of the flag vector.
REQ-002 Parameter SEL_BITS, default 5: sprite index width.
REQ-003 Parameter DATA_BITS, default 32: sprite word width.
REQ-004 Parameter SPRITE_SIZE, default 20: sprite edge in pixels, square.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port reset, input, 1: reset, synchronous and active-low.
REQ-007 Port enable_refresh_flags, input, 1: evaluate-pair request from the collision controller.
REQ-008 Port reset_refresh_mod, input, 1: active-low clear of the working flags.
REQ-009 Port analyze_process_finished, input, 1: low means the collision pass is complete.
REQ-010 Port number_of_mobile_sprite, input, SEL_BITS: index of the mobile sprite.
REQ-011 Port number_of_comparison_sprite, input, SEL_BITS: index of the comparison sprite.
REQ-012 Port out_m_sprite, input, DATA_BITS: mobile sprite word.
REQ-013 Port out_c_sprite, input, DATA_BITS: comparison sprite word.
REQ-014 Port collision_flags, output, N_SPRITE: last published flag snapshot; bit i = sprite i collided.
REQ-015 Port flags_valid, output, 1: one-cycle pulse when collision_flags is updated.
REQ-016 Port collision_count, output, 8: colliding pairs in the published pass.

Function
REQ-017 Sprite word fields: bit 29 active; [28:19] x (10 b unsigned); [18:9] y (10 b unsigned); other bits ignored.
REQ-018 Request detection: rising edge of enable_refresh_flags (current 1, previous-cycle sample 0); a held level triggers once only.
REQ-019 Stage S1 (cycle after the request edge) registers both indices, both x, both y, and both active bits.
REQ-020 Stage S2 computes dx = |xm - xc| and dy = |ym - yc| with 11-bit signed subtraction then magnitude; hit = active_m & active_c & (index_m != index_c) & (dx < SPRITE_SIZE) & (dy < SPRITE_SIZE).
REQ-021 Stage S3: on hit, set working-flag bits index_m and index_c (sticky OR); pair counter increments, saturating at 255.
REQ-022 Latency: request edge at cycle T; working flags reflect the pair at T+3; a new edge is accepted every cycle (fully pipelined).
REQ-023 Index >= N_SPRITE: no flag set, counter unchanged.
REQ-024 reset_refresh_mod low: working flags and pair counter cleared to 0, and in-flight S1/S2 entries invalidated; clear wins over a simultaneous S3 set.
REQ-025 Publish FSM states: IDLE, DRAIN, PUBLISH.
REQ-026 IDLE -> DRAIN on falling edge of analyze_process_finished.
REQ-027 DRAIN holds until S1 and S2 are both invalid and no request edge is present that cycle, then -> PUBLISH.
REQ-028 PUBLISH, one cycle: collision_flags <= working flags including any S3 update of that cycle; collision_count <= pair counter; flags_valid = 1; -> IDLE.
REQ-029 Falling edge of analyze_process_finished in DRAIN or PUBLISH is ignored; collision_flags is stable except in PUBLISH.
REQ-030 reset_refresh_mod low during DRAIN aborts to IDLE without publishing.

Reset
REQ-031 reset low at a rising edge: collision_flags = 0, collision_count = 0, flags_valid = 0, working flags = 0, pipeline invalid, edge-detect registers = 0, FSM = IDLE.
REQ-032 Reset has priority over every other input, including mid-pipeline and mid-DRAIN.

Verification
REQ-033 Mobile 0 at (100,100) active, comparison 3 at (115,110) active, edge, then finish -> collision_flags = 0x00000009, count = 1, flags_valid exactly one cycle.
REQ-034 Same pair at (100,100)/(120,100) (dx = 20) -> no bits set, count = 0; at (119,100) -> bits 0 and 3 set.
REQ-035 Comparison inactive (bit 29 = 0) at an overlapping position -> no flag set.
REQ-036 Edge on the last pair and finish falling in the same cycle -> publish waits for drain; that pair's bits are present in the snapshot.
REQ-037 Flags set, reset_refresh_mod pulsed low, new pass with no hits -> published flags = 0, count = 0.
REQ-038 enable_refresh_flags held high 5 cycles on one hit pair -> count = 1; 300 hit pairs -> count = 255.
